// File: rtl/link_train_ctrl.sv
// link_train_ctrl
// Steps the 16-bit word-alignment datapath through link bring-up and keeps
// watching the live link afterwards. The sequence is: pulse the aligner's
// PHY_INIT, wait for lock, confirm lock by counting sync words, then monitor
// for loss. It also owns the retry policy.
//
// Ports:
//   clk_i       clock; all logic is rising-edge
//   rst_i       synchronous active-high reset
//   en_i        training enable; low forces IDLE and clears the retry count
//   aligned_i   lock flag from the aligner
//   dipush_i    aligned word valid
//   din_i       aligned 16-bit word
//   phy_init_o  aligner/PHY re-initialise (high while in INIT)
//   link_up_o   link verified and healthy (high while in UP)
//   fail_o      retries exhausted (high while in FAIL)
//   state_o     current state code (IDLE=0 INIT=1 HUNT=2 VERIFY=3 UP=4 FAIL=5)
//   retry_o     failed attempts since the last UP or IDLE
module link_train_ctrl #(
  parameter logic [15:0] SYNC_WORD  = 16'hF731,
  parameter int          INIT_CYC   = 16,
  parameter int          HUNT_TO    = 4096,
  parameter int          VERIFY_N   = 4,
  parameter int          LOSS_WORDS = 1024,
  parameter int          MAX_RETRY  = 7
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        aligned_i,
  input  logic        dipush_i,
  input  logic [15:0] din_i,
  output logic        phy_init_o,
  output logic        link_up_o,
  output logic        fail_o,
  output logic [2:0]  state_o,
  output logic [3:0]  retry_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_HUNT   = 3'd2,
    S_VERIFY = 3'd3,
    S_UP     = 3'd4,
    S_FAIL   = 3'd5
  } state_e;

  localparam int CYC_MAX  = (INIT_CYC > HUNT_TO) ? INIT_CYC : HUNT_TO;
  localparam int WORD_MAX = (VERIFY_N > LOSS_WORDS) ? VERIFY_N : LOSS_WORDS;
  localparam int CW       = $clog2(CYC_MAX + 1);
  localparam int WW       = $clog2(WORD_MAX + 1);

  localparam logic [CW-1:0] INIT_LAST   = CW'(INIT_CYC - 1);
  localparam logic [CW-1:0] HUNT_LAST   = CW'(HUNT_TO - 1);
  localparam logic [WW-1:0] VERIFY_LAST = WW'(VERIFY_N - 1);
  localparam logic [WW-1:0] LOSS_LAST   = WW'(LOSS_WORDS - 1);
  localparam logic [3:0]    RETRY_MAX   = 4'(MAX_RETRY);

  state_e        state_q, state_d;
  logic [3:0]    retry_q, retry_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [WW-1:0] word_q, word_d;
  logic          phy_init_q, link_up_q, fail_q;
  logic          sync_hit, retry_evt;

  assign sync_hit = dipush_i && (din_i == SYNC_WORD);

  // Next-state logic. Inside each state the priority is: ALIGNED drop,
  // then a sync word, then a timeout or count limit. EN low overrides all
  // of these afterwards, and any state change clears both counters.
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    cyc_d     = cyc_q;
    word_d    = word_q;
    retry_evt = 1'b0;

    case (state_q)
      S_IDLE: begin
        retry_d = '0;
        state_d = S_INIT;
      end
      S_INIT: begin
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == INIT_LAST) state_d = S_HUNT;
      end
      S_HUNT: begin
        cyc_d = cyc_q + 1'b1;
        if (aligned_i)               state_d   = S_VERIFY;
        else if (cyc_q == HUNT_LAST) retry_evt = 1'b1;
      end
      S_VERIFY: begin
        cyc_d = cyc_q + 1'b1;
        if (!aligned_i) begin
          retry_evt = 1'b1;
        end else if (sync_hit && word_q == VERIFY_LAST) begin
          state_d = S_UP;
          retry_d = '0;
        end else if (cyc_q == HUNT_LAST) begin
          retry_evt = 1'b1;
        end else if (sync_hit) begin
          word_d = word_q + 1'b1;
        end
      end
      S_UP: begin
        // A sync word always clears the loss run, even on the cycle that
        // would otherwise complete it.
        if (!aligned_i) begin
          retry_evt = 1'b1;
        end else if (dipush_i) begin
          if (sync_hit)                word_d    = '0;
          else if (word_q == LOSS_LAST) retry_evt = 1'b1;
          else                          word_d    = word_q + 1'b1;
        end
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (retry_evt) begin
      if (retry_q == RETRY_MAX) begin
        state_d = S_FAIL;
      end else begin
        retry_d = retry_q + 4'd1;
        state_d = S_INIT;
      end
    end

    if (!en_i) begin
      state_d = S_IDLE;
      retry_d = '0;
    end

    if (state_d != state_q) begin
      cyc_d  = '0;
      word_d = '0;
    end
  end

  // State, counters and outputs. The outputs are decoded from the next
  // state so they change on the same edge as the state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      retry_q    <= '0;
      cyc_q      <= '0;
      word_q     <= '0;
      phy_init_q <= 1'b0;
      link_up_q  <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      cyc_q      <= cyc_d;
      word_q     <= word_d;
      phy_init_q <= (state_d == S_INIT);
      link_up_q  <= (state_d == S_UP);
      fail_q     <= (state_d == S_FAIL);
    end
  end

  assign phy_init_o = phy_init_q;
  assign link_up_o  = link_up_q;
  assign fail_o     = fail_q;
  assign state_o    = state_q;
  assign retry_o    = retry_q;

endmodule
